// File: rtl/cpu_dbg_pkg.sv
// Shared encodings and defaults for the CPU clock-enable sequencer and its debounce helper.
// Pure declarations: no latency, no flow control.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_STEP    = 3'd1,
        ST_SLOW    = 3'd2,
        ST_FULL    = 3'd3,
        ST_BP_HALT = 3'd4
    } state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FULL = 2'b11;

    localparam int SLOW_DIV_DEFAULT        = 25_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;
    localparam int CNT_W_DEFAULT           = 32;

    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_STEP: return ST_STEP;
            MODE_SLOW: return ST_SLOW;
            MODE_FULL: return ST_FULL;
            default:   return ST_HALT;
        endcase
    endfunction

    function automatic logic is_running(input state_t s);
        return (s == ST_SLOW) || (s == ST_FULL);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, then level changes after DEBOUNCE_CYCLES stable cycles; rise pulses once.
// Latency 2 + DEBOUNCE_CYCLES cycles; free-running, no backpressure.
module btn_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            rise <= 1'b0;
            // Any return to the current level restarts the stability window.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// 6502 clock-enable sequencer: halt/step/slow/full modes, breakpoint halt, single owed cycle across mem_rdy stalls.
// cpu_ce is registered (one cycle after tick); mode_sw takes 2 sync cycles; mem_rdy low defers at most one cycle.
module cpu_clock_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int SLOW_DIV        = SLOW_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [1:0]       mode_sw,
    input  logic [2:0]       div_sel,
    input  logic             step_btn,
    input  logic             bp_halt,
    input  logic             mem_rdy,
    output logic             cpu_ce,
    output logic             running,
    output logic             bp_hit,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_count
);

    logic [1:0]       mode_meta;
    logic [1:0]       mode_sync;
    state_t           state;
    state_t           mode_state;
    logic [CNT_W-1:0] slow_cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] div_shift;
    logic [CNT_W-1:0] period_next;
    logic             pending;
    logic             tick;
    logic             step_level;
    logic             step_rise;
    logic             step_evt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_raw(step_btn),
        .level  (step_level),
        .rise   (step_rise)
    );

    assign step_evt    = step_rise & step_level;
    assign mode_state  = mode_to_state(mode_sync);
    assign div_shift   = CNT_W'(SLOW_DIV) >> div_sel;
    assign period_next = (div_shift == '0) ? CNT_W'(1) : div_shift;
    assign state_o     = state;

    always_comb begin
        tick = 1'b0;
        case (state)
            ST_FULL: tick = 1'b1;
            ST_SLOW: tick = (slow_cnt >= period - CNT_W'(1));
            ST_STEP: tick = step_evt;
            default: tick = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mode_meta   <= MODE_HALT;
            mode_sync   <= MODE_HALT;
            state       <= ST_HALT;
            slow_cnt    <= '0;
            period      <= CNT_W'(1);
            pending     <= 1'b0;
            cpu_ce      <= 1'b0;
            cycle_count <= '0;
            running     <= 1'b0;
            bp_hit      <= 1'b0;
        end else begin
            mode_meta <= mode_sw;
            mode_sync <= mode_meta;
            cpu_ce    <= 1'b0;
            if (state == ST_BP_HALT) begin
                // Resume without issuing a cycle; pending was already discarded on entry.
                if (step_evt) begin
                    state    <= mode_state;
                    slow_cnt <= '0;
                    period   <= period_next;
                    running  <= is_running(mode_state);
                    bp_hit   <= 1'b0;
                end
            end else if (bp_halt) begin
                state    <= ST_BP_HALT;
                slow_cnt <= '0;
                pending  <= 1'b0;
                running  <= 1'b0;
                bp_hit   <= 1'b1;
            end else if (mode_state != state) begin
                state    <= mode_state;
                slow_cnt <= '0;
                period   <= period_next;
                pending  <= 1'b0;
                running  <= is_running(mode_state);
            end else begin
                if (state == ST_SLOW) begin
                    if (tick) begin
                        slow_cnt <= '0;
                        period   <= period_next;
                    end else begin
                        slow_cnt <= slow_cnt + CNT_W'(1);
                    end
                end
                if (tick || pending) begin
                    if (mem_rdy) begin
                        cpu_ce      <= 1'b1;
                        pending     <= 1'b0;
                        cycle_count <= cycle_count + CNT_W'(1);
                    end else begin
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: stimulus queues expected cpu_ce pulses, a negedge monitor retires them.
// Small SLOW_DIV/DEBOUNCE_CYCLES and an 8-bit counter keep every scenario short and make wrap reachable.
module tb_cpu_clock_ctrl;

    localparam int CNT_W = 8;

    logic             clk_in   = 1'b0;
    logic             rst      = 1'b1;
    logic [1:0]       mode_sw  = 2'b00;
    logic [2:0]       div_sel  = 3'd0;
    logic             step_btn = 1'b0;
    logic             bp_halt  = 1'b0;
    logic             mem_rdy  = 1'b1;
    logic             cpu_ce;
    logic             running;
    logic             bp_hit;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        int cnt;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   fails    = 0;
    int   cyc_no   = 0;
    int   last_ce  = 0;
    int   next_cnt = 0;

    cpu_clock_ctrl #(
        .SLOW_DIV       (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .mode_sw    (mode_sw),
        .div_sel    (div_sel),
        .step_btn   (step_btn),
        .bp_halt    (bp_halt),
        .mem_rdy    (mem_rdy),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .bp_hit     (bp_hit),
        .state_o    (state_o),
        .cycle_count(cycle_count)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_no <= cyc_no + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_no);
        end
    endtask

    // gap = expected cycles since previous pulse; 0 means not checked.
    task automatic push(input int gap);
        exp_t e;
        next_cnt = next_cnt + 1;
        e.cnt = next_cnt % (1 << CNT_W);
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    always @(negedge clk_in) begin
        if (cpu_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ce: cpu_ce=1 cycle_count=%0d, expected no pulse (cycle %0d)",
                         cycle_count, cyc_no);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ce_cycle_count", int'(cycle_count), mon_e.cnt);
                if (mon_e.gap != 0) chk("ce_gap", cyc_no - last_ce, mon_e.gap);
            end
            last_ce = cyc_no;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        #1 rst = 1'b0;
        cyc(2);
        chk("reset_state", int'(state_o), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_bp_hit", int'(bp_hit), 0);
        chk("reset_count", int'(cycle_count), 0);
        chk("reset_ce", int'(cpu_ce), 0);

        // Slow run, P = 8: first pulse 11 cycles after the switch, then every 8.
        mode_sw = 2'b10;
        div_sel = 3'd0;
        push(0);
        repeat (9) push(8);
        drain(120);
        chk("slow_running", int'(running), 1);
        chk("slow_state", int'(state_o), 2);
        mode_sw = 2'b00;
        cyc(6);
        chk("halt_state", int'(state_o), 0);
        chk("halt_running", int'(running), 0);

        // P = 2, then div_sel=7 clamps P to 1 from the next wrap.
        div_sel = 3'd2;
        mode_sw = 2'b10;
        push(0);
        repeat (3) push(2);
        drain(40);
        div_sel = 3'd7;
        push(2);
        repeat (5) push(1);
        cyc(4);
        mode_sw = 2'b00;
        cyc(8);
        chk("div_queue_empty", exp_q.size(), 0);
        chk("div_halt_state", int'(state_o), 0);

        // Step mode with a bouncing press: exactly one pulse.
        mode_sw = 2'b01;
        cyc(5);
        chk("step_state", int'(state_o), 1);
        chk("step_running", int'(running), 0);
        push(0);
        step_btn = 1'b1;
        cyc(1);
        step_btn = 1'b0;
        cyc(1);
        step_btn = 1'b1;
        cyc(20);
        step_btn = 1'b0;
        cyc(20);
        chk("step_queue_empty", exp_q.size(), 0);

        // Full speed with mem_rdy stalled: nothing until ready, then one pulse per cycle.
        mem_rdy = 1'b0;
        mode_sw = 2'b11;
        cyc(3);
        chk("full_state", int'(state_o), 3);
        cyc(5);
        chk("stall_no_ce", int'(cpu_ce), 0);
        mem_rdy = 1'b1;
        push(0);
        repeat (5) push(1);
        cyc(6);
        bp_halt = 1'b1;
        cyc(1);
        bp_halt = 1'b0;
        chk("bp_state", int'(state_o), 4);
        chk("bp_hit", int'(bp_hit), 1);
        chk("bp_running", int'(running), 0);
        chk("bp_ce", int'(cpu_ce), 0);
        chk("full_queue_empty", exp_q.size(), 0);

        // Breakpoint ignores mode changes; a step press resumes FULL with no extra cycle.
        mode_sw = 2'b00;
        cyc(6);
        chk("bp_hold_halt_sw", int'(state_o), 4);
        mode_sw = 2'b10;
        cyc(6);
        chk("bp_hold_slow_sw", int'(state_o), 4);
        mode_sw = 2'b11;
        cyc(4);
        step_btn = 1'b1;
        cyc(7);
        chk("bp_exit_state", int'(state_o), 3);
        chk("bp_exit_no_ce", int'(cpu_ce), 0);
        chk("bp_exit_running", int'(running), 1);
        chk("bp_exit_bp_hit", int'(bp_hit), 0);
        push(0);
        push(1);
        mode_sw = 2'b10;
        push(2);
        repeat (3) push(1);
        cyc(7);

        // Reset mid-SLOW while cpu_ce is high.
        @(negedge clk_in);
        #1;
        chk("pre_reset_ce", int'(cpu_ce), 1);
        rst = 1'b1;
        step_btn = 1'b0;
        #1;
        chk("async_reset_ce", int'(cpu_ce), 0);
        chk("async_reset_count", int'(cycle_count), 0);
        chk("async_reset_state", int'(state_o), 0);
        chk("pre_reset_queue_empty", exp_q.size(), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        #1 rst = 1'b0;
        next_cnt = 0;
        @(posedge clk_in);
        #1;
        chk("release_edge1_state", int'(state_o), 0);
        @(posedge clk_in);
        #1;
        chk("release_edge2_state", int'(state_o), 0);
        chk("release_edge2_count", int'(cycle_count), 0);
        @(posedge clk_in);
        #1;
        chk("release_edge3_state", int'(state_o), 2);

        // Continuous P = 1 slow run long enough to wrap the 8-bit cycle counter.
        push(0);
        repeat (259) push(1);
        cyc(258);
        mode_sw = 2'b00;
        cyc(8);
        chk("wrap_queue_empty", exp_q.size(), 0);
        chk("final_state", int'(state_o), 0);
        chk("final_running", int'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
